prog_run_sequencer: RTL and testbench

- Sequences one program run on the single-cycle core (TopLevel): writes operand bytes into data memory, releases the core's start, waits for halt, reads result bytes back, reports result and status.
- Sits between a host/loader and the core: owns the data-memory side port and the core's start line; the core owns memory only while running.
- Serves the three course programs: 0 = 1/x, 1 = 16/8 divide, 2 = square root.

---
 rtl/prog_run_sequencer.sv | 255 +++++++++++++++++++++++++
 tb/tb_prog_run_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_run_sequencer.sv
// Sequences one program run on the single-cycle core: load operands, launch, wait for halt, read results.
// Optional build macro SEQ_CLEAR_MEM_EN adds a CLEAR pass that zeroes all 256 data-memory bytes before loading.
module prog_run_sequencer #(
    parameter logic [7:0]  P0_OP_ADDR     = 8'd0,
    parameter logic [7:0]  P0_RES_ADDR    = 8'd2,
    parameter logic [7:0]  P1_OP_ADDR     = 8'd8,
    parameter logic [7:0]  P1_RES_ADDR    = 8'd11,
    parameter logic [7:0]  P2_OP_ADDR     = 8'd16,
    parameter logic [7:0]  P2_RES_ADDR    = 8'd18,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        req,
    input  logic [1:0]  prog_sel,
    input  logic [23:0] operand,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [23:0] result,
    output logic        core_start,
    input  logic        core_halt,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata
);
    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LOAD, S_LAUNCH, S_WAIT, S_READ, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       prog_q, prog_d;
    logic [23:0]      operand_q, operand_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [23:0]      result_q, result_d;
    logic             core_start_q, core_start_d;
    logic             mem_we_q, mem_we_d;
    logic [7:0]       mem_addr_q, mem_addr_d;
    logic [7:0]       mem_wdata_q, mem_wdata_d;

    // Per-program memory map and byte counts.
    function automatic logic [7:0] op_base(input logic [1:0] p);
        case (p)
            2'd0:    return P0_OP_ADDR;
            2'd1:    return P1_OP_ADDR;
            default: return P2_OP_ADDR;
        endcase
    endfunction

    function automatic logic [7:0] res_base(input logic [1:0] p);
        case (p)
            2'd0:    return P0_RES_ADDR;
            2'd1:    return P1_RES_ADDR;
            default: return P2_RES_ADDR;
        endcase
    endfunction

    function automatic logic [1:0] op_len(input logic [1:0] p);
        return (p == 2'd1) ? 2'd3 : 2'd2;
    endfunction

    function automatic logic [1:0] res_len(input logic [1:0] p);
        case (p)
            2'd0:    return 2'd2;
            2'd1:    return 2'd3;
            default: return 2'd1;
        endcase
    endfunction

    function automatic logic [7:0] pick_byte(input logic [23:0] v, input logic [1:0] pos);
        case (pos)
            2'd0:    return v[7:0];
            2'd1:    return v[15:8];
            default: return v[23:16];
        endcase
    endfunction

    function automatic logic [23:0] put_byte(input logic [23:0] v, input logic [7:0] b,
                                             input logic [1:0] pos);
        logic [23:0] r;
        r = v;
        case (pos)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            default: r[23:16] = b;
        endcase
        return r;
    endfunction

    // Next state plus the registered output values for the state being entered.
    always_comb begin
        state_d      = state_q;
        prog_d       = prog_q;
        operand_d    = operand_q;
        idx_d        = idx_q;
        wait_d       = wait_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = err_q;
        result_d     = result_q;
        core_start_d = 1'b1;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    busy_d    = 1'b1;
                    err_d     = 1'b0;
                    prog_d    = prog_sel;
                    operand_d = operand;
                    idx_d     = 2'd0;
                    if (prog_sel == 2'd3) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
`ifdef SEQ_CLEAR_MEM_EN
                        state_d     = S_CLEAR;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = 8'd0;
                        mem_wdata_d = 8'd0;
`else
                        state_d     = S_LOAD;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = op_base(prog_sel);
                        mem_wdata_d = pick_byte(operand, op_len(prog_sel) - 2'd1);
`endif
                    end
                end
            end

            S_CLEAR: begin
`ifdef SEQ_CLEAR_MEM_EN
                mem_we_d = 1'b1;
                if (mem_addr_q == 8'hFF) begin
                    state_d     = S_LOAD;
                    mem_addr_d  = op_base(prog_q);
                    mem_wdata_d = pick_byte(operand_q, op_len(prog_q) - 2'd1);
                end else begin
                    mem_addr_d  = mem_addr_q + 8'd1;
                    mem_wdata_d = 8'd0;
                end
`else
                state_d = S_IDLE;
`endif
            end

            S_LOAD: begin
                if (idx_q == op_len(prog_q) - 2'd1) begin
                    state_d      = S_LAUNCH;
                    core_start_d = 1'b0;
                end else begin
                    idx_d       = idx_q + 2'd1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = op_base(prog_q) + 8'(idx_q) + 8'd1;
                    mem_wdata_d = pick_byte(operand_q, op_len(prog_q) - 2'd2 - idx_q);
                end
            end

            S_LAUNCH: begin
                state_d      = S_WAIT;
                core_start_d = 1'b0;
                wait_d       = '0;
            end

            // wait_q == 0 is the first WAIT cycle, where a leftover halt is masked.
            S_WAIT: begin
                if (core_halt && (wait_q != '0)) begin
                    state_d    = S_READ;
                    idx_d      = 2'd0;
                    mem_addr_d = res_base(prog_q);
                    result_d   = '0;
                end else if (wait_q == CNT_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    core_start_d = 1'b0;
                    wait_d       = wait_q + CNT_W'(1);
                end
            end

            S_READ: begin
                result_d = put_byte(result_q, mem_rdata, res_len(prog_q) - 2'd1 - idx_q);
                if (idx_q == res_len(prog_q) - 2'd1) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d      = idx_q + 2'd1;
                    mem_addr_d = res_base(prog_q) + 8'(idx_q) + 8'd1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            prog_q       <= 2'd0;
            operand_q    <= 24'd0;
            idx_q        <= 2'd0;
            wait_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            result_q     <= 24'd0;
            core_start_q <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 8'd0;
            mem_wdata_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            prog_q       <= prog_d;
            operand_q    <= operand_d;
            idx_q        <= idx_d;
            wait_q       <= wait_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            result_q     <= result_d;
            core_start_q <= core_start_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // A pending write or done pulse must not escape during a reset cycle.
    assign mem_we     = mem_we_q & ~Reset;
    assign done       = done_q & ~Reset;
    assign busy       = busy_q;
    assign err        = err_q;
    assign result     = result_q;
    assign core_start = core_start_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_prog_run_sequencer.sv
// Bench for prog_run_sequencer: data memory and core stub, vector table, corner sequences, random runs.
module tb_prog_run_sequencer;
    logic        CLK = 1'b0;
    logic        Reset, req, busy, done, err, core_start, core_halt, mem_we;
    logic [1:0]  prog_sel;
    logic [23:0] operand, result;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata;

    prog_run_sequencer dut (
        .CLK(CLK), .Reset(Reset), .req(req), .prog_sel(prog_sel), .operand(operand),
        .busy(busy), .done(done), .err(err), .result(result), .core_start(core_start),
        .core_halt(core_halt), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

`ifdef SEQ_CLEAR_MEM_EN
    localparam int CLR_LAT = 256;
`else
    localparam int CLR_LAT = 0;
`endif
    localparam int LAT_LIMIT = 6000;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        int          p;
        logic [23:0] op;
        int          h;
        logic [7:0]  r0, r1, r2;
        logic [23:0] exp_res;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    wr_t  wr_q [$];
    wr_t  exp_q[$];

    // Data memory and a core stub that halts on a chosen WAIT cycle after writing its result bytes.
    logic [7:0] mem [256];
    logic [7:0] stub_res [3];
    logic [7:0] stub_addr = 8'd0;
    int         stub_h = 0;
    int         stub_n = 0;
    int         low_seen = 0;
    logic       halt_force = 1'b0;

    assign mem_rdata = mem[mem_addr];
    assign core_halt = halt_force | ((stub_h != 0) && !core_start && (low_seen == stub_h));

    always @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wr_q.push_back({mem_addr, mem_wdata});
        end
        if (core_halt && !core_start && (stub_h != 0))
            for (int k = 0; k < stub_n; k++) mem[stub_addr + 8'(k)] <= stub_res[k];
        low_seen <= core_start ? 0 : low_seen + 1;
    end

    // Reference model: memory map, byte counts and latency straight from the program rules.
    function automatic int n_op(input int p);
        return (p == 1) ? 3 : 2;
    endfunction
    function automatic int n_res(input int p);
        return (p == 0) ? 2 : (p == 1) ? 3 : 1;
    endfunction
    function automatic int op_base(input int p);
        return (p == 0) ? 0 : (p == 1) ? 8 : 16;
    endfunction
    function automatic int res_base(input int p);
        return (p == 0) ? 2 : (p == 1) ? 11 : 18;
    endfunction
    function automatic logic [23:0] exp_result(input int p, input logic [7:0] r0, r1, r2);
        logic [23:0] all;
        all = {r0, r1, r2};
        return all >> (8 * (3 - n_res(p)));
    endfunction
    function automatic int exp_latency(input int p, input int h);
        return (p == 3) ? 1 : 1 + n_op(p) + 1 + h + n_res(p) + CLR_LAT;
    endfunction

    task automatic build_exp(input int p, input logic [23:0] op);
        wr_t w;
        exp_q.delete();
        if (p != 3) begin
`ifdef SEQ_CLEAR_MEM_EN
            for (int a = 0; a < 256; a++) begin
                w.a = 8'(a);
                w.d = 8'h00;
                exp_q.push_back(w);
            end
`endif
            for (int k = 0; k < n_op(p); k++) begin
                w.a = 8'(op_base(p) + k);
                w.d = 8'((op >> (8 * (n_op(p) - 1 - k))) & 24'hFF);
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic check_writes(input string nm);
        check({nm, "_nwr"}, 32'(wr_q.size()), 32'(exp_q.size()));
        if (wr_q.size() == exp_q.size())
            foreach (exp_q[i]) check({nm, "_wr"}, 32'(wr_q[i]), 32'(exp_q[i]));
    endtask

    // Issue one request from IDLE and return what was seen on the done cycle.
    task automatic run_one(input int p, input logic [23:0] op, input int h,
                           input logic [7:0] r0, r1, r2,
                           output logic [23:0] g_res, output logic g_err,
                           output int g_lat, output logic g_cs);
        stub_h      = (p == 3) ? 0 : h;
        stub_n      = (p == 3) ? 0 : n_res(p);
        stub_addr   = (p == 3) ? 8'd0 : 8'(res_base(p));
        stub_res[0] = r0;
        stub_res[1] = r1;
        stub_res[2] = r2;
        wr_q.delete();
        prog_sel = 2'(p);
        operand  = op;
        req      = 1'b1;
        g_lat    = 0;
        while (g_lat < LAT_LIMIT) begin
            @(posedge CLK);
            #1;
            req = 1'b0;
            g_lat++;
            if (done) break;
        end
        g_res = result;
        g_err = err;
        g_cs  = core_start;
        @(posedge CLK);
        #1;
        stub_h = 0;
    endtask

    vec_t        tbl [4];
    logic [23:0] g_res, prev_res, e_res;
    logic        g_err, g_cs;
    int          g_lat, n_done, p, h;
    logic [23:0] op;
    logic [7:0]  r0, r1, r2;

    initial begin
        Reset = 1'b1; req = 1'b0; prog_sel = 2'd0; operand = 24'd0;
        repeat (3) @(posedge CLK);
        #1 Reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_core_start", 32'(core_start), 32'd1);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);

        tbl[0] = '{p: 2, op: 24'h0000D3, h: 10, r0: 8'h0F, r1: 8'h00, r2: 8'h00,
                   exp_res: 24'h00000F, exp_err: 1'b0, exp_lat: 15};
        tbl[1] = '{p: 1, op: 24'h006407, h: 3, r0: 8'h0E, r1: 8'h4A, r2: 8'h49,
                   exp_res: 24'h0E4A49, exp_err: 1'b0, exp_lat: 11};
        tbl[2] = '{p: 0, op: 24'h001234, h: 2, r0: 8'hAB, r1: 8'hCD, r2: 8'h00,
                   exp_res: 24'h00ABCD, exp_err: 1'b0, exp_lat: 8};
        tbl[3] = '{p: 3, op: 24'h123456, h: 5, r0: 8'h11, r1: 8'h22, r2: 8'h33,
                   exp_res: 24'h00ABCD, exp_err: 1'b1, exp_lat: 1};
        for (int i = 0; i < 4; i++) begin
            run_one(tbl[i].p, tbl[i].op, tbl[i].h, tbl[i].r0, tbl[i].r1, tbl[i].r2,
                    g_res, g_err, g_lat, g_cs);
            build_exp(tbl[i].p, tbl[i].op);
            check($sformatf("vec%0d_result", i), 32'(g_res), 32'(tbl[i].exp_res));
            check($sformatf("vec%0d_err", i), 32'(g_err), 32'(tbl[i].exp_err));
            check($sformatf("vec%0d_lat", i), 32'(g_lat),
                  32'(tbl[i].exp_lat + ((tbl[i].p == 3) ? 0 : CLR_LAT)));
            check_writes($sformatf("vec%0d", i));
            check($sformatf("vec%0d_idle", i), 32'(busy), 32'd0);
        end
        prev_res = 24'h00ABCD;

        // Timeout: halt never rises.
        run_one(0, 24'h000003, 0, 8'h00, 8'h00, 8'h00, g_res, g_err, g_lat, g_cs);
        build_exp(0, 24'h000003);
        check("tmo_err", 32'(g_err), 32'd1);
        check("tmo_lat", 32'(g_lat), 32'(1 + 2 + 1 + 4096 + CLR_LAT));
        check("tmo_result", 32'(g_res), 32'(prev_res));
        check("tmo_core_start", 32'(g_cs), 32'd1);
        check_writes("tmo");

        // Requests while busy and in the DONE cycle are dropped.
        stub_h = 6; stub_n = 1; stub_addr = 8'd18; stub_res[0] = 8'h3C;
        wr_q.delete();
        build_exp(2, 24'h000090);
        prog_sel = 2'd2; operand = 24'h000090; req = 1'b1;
        @(posedge CLK);
        #1 req = 1'b0;
        repeat (4 + CLR_LAT) @(posedge CLK);
        #1 prog_sel = 2'd0; operand = 24'hFFFFFF; req = 1'b1;
        @(posedge CLK);
        #1 req = 1'b0;
        n_done = 0;
        g_res = '0; g_err = 1'b1;
        for (int c = 0; c < 40 + CLR_LAT; c++) begin
            @(posedge CLK);
            #1;
            if (done) begin
                n_done++;
                g_res = result;
                g_err = err;
                prog_sel = 2'd3;
                req = 1'b1;
            end else begin
                req = 1'b0;
            end
        end
        stub_h = 0;
        check("busyreq_ndone", 32'(n_done), 32'd1);
        check("busyreq_result", 32'(g_res), 32'h00003C);
        check("busyreq_err", 32'(g_err), 32'd0);
        check_writes("busyreq");
        check("busyreq_idle", 32'(busy), 32'd0);

        // Stale halt high through LOAD, LAUNCH and the first WAIT cycle.
        halt_force = 1'b1;
        fork
            run_one(2, 24'h000040, 5, 8'h08, 8'h00, 8'h00, g_res, g_err, g_lat, g_cs);
            begin
                repeat (5 + CLR_LAT) @(posedge CLK);
                #1 halt_force = 1'b0;
            end
        join
        check("stale_lat", 32'(g_lat), 32'(exp_latency(2, 5)));
        check("stale_result", 32'(g_res), 32'h000008);
        check("stale_err", 32'(g_err), 32'd0);

        // Reset in the middle of WAIT aborts silently.
        stub_h = 0;
        prog_sel = 2'd2; operand = 24'h000011; req = 1'b1;
        @(posedge CLK);
        #1 req = 1'b0;
        repeat (5 + CLR_LAT) @(posedge CLK);
        #1 Reset = 1'b1;
        n_done = done ? 1 : 0;
        @(posedge CLK);
        #1 Reset = 1'b0;
        check("rstwait_busy", 32'(busy), 32'd0);
        check("rstwait_core_start", 32'(core_start), 32'd1);
        check("rstwait_result", 32'(result), 32'd0);
        for (int c = 0; c < 20; c++) begin
            if (done) n_done++;
            @(posedge CLK);
            #1;
        end
        check("rstwait_ndone", 32'(n_done), 32'd0);
        run_one(2, 24'h000051, 4, 8'h09, 8'h00, 8'h00, g_res, g_err, g_lat, g_cs);
        build_exp(2, 24'h000051);
        check("fresh_result", 32'(g_res), 32'h000009);
        check("fresh_err", 32'(g_err), 32'd0);
        check("fresh_lat", 32'(g_lat), 32'(9 + CLR_LAT));
        check_writes("fresh");
        prev_res = 24'h000009;

        // Random runs against the model.
        for (int i = 0; i < 24; i++) begin
            p  = $urandom_range(0, 3);
            op = 24'($urandom);
            h  = $urandom_range(2, 12);
            r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom);
            run_one(p, op, h, r0, r1, r2, g_res, g_err, g_lat, g_cs);
            build_exp(p, op);
            e_res = (p == 3) ? prev_res : exp_result(p, r0, r1, r2);
            check($sformatf("rnd%0d_p%0d_result", i, p), 32'(g_res), 32'(e_res));
            check($sformatf("rnd%0d_p%0d_err", i, p), 32'(g_err), 32'(p == 3));
            check($sformatf("rnd%0d_p%0d_lat", i, p), 32'(g_lat), 32'(exp_latency(p, h)));
            check($sformatf("rnd%0d_p%0d_cs", i, p), 32'(g_cs), 32'd1);
            check_writes($sformatf("rnd%0d", i));
            prev_res = e_res;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
